// File: rtl/dgw_enable_seq_pkg.sv
// Shared constants, FSM state encoding and the group one-hot helper for the
// DGW enable sequencer.
package dgw_pkg;
  localparam int NUM_GROUPS = 16;
  localparam int ADDR_W     = 4;
  localparam int LEN_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_GROUPS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_GROUPS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/dgw_enable_seq_if.sv
// Burst request handshake between a requester and the enable sequencer.
interface dgw_enable_seq_if;
  import dgw_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              req_bcast;

  modport master (output req_valid, req_addr, req_len, req_bcast, input req_ready);
  modport slave  (input req_valid, req_addr, req_len, req_bcast, output req_ready);
endinterface

// File: rtl/dgw_enable_seq_onehot_dec.sv
// Group index to one-hot enable decoder with broadcast override and kill mask.
module dgw_onehot_dec
  import dgw_pkg::*;
(
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  bcast,
  input  logic [NUM_GROUPS-1:0] grp_disable,
  output logic [NUM_GROUPS-1:0] grp_en
);
  always_comb begin
    grp_en = (bcast ? {NUM_GROUPS{1'b1}} : onehot(addr)) & ~grp_disable;
  end
endmodule

// File: rtl/dgw_enable_seq.sv
// Converts burst requests into a registered one-hot-per-cycle group enable
// bus E for the downstream clock gates, with an idle gap between bursts.
module dgw_enable_seq
  import dgw_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dgw_enable_seq_if.slave       req,
  input  logic [NUM_GROUPS-1:0] grp_disable,
  output logic [NUM_GROUPS-1:0] E,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cur_q, cur_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [1:0]            gap_q, gap_d;
  logic [NUM_GROUPS-1:0] e_q, e_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ADDR_W-1:0]     dec_addr;
  logic                  dec_bcast;
  logic [NUM_GROUPS-1:0] dec_en;
  logic                  accept;

  assign req.req_ready = (state_q == IDLE) && !rst;
  assign accept        = req.req_valid && req.req_ready;

  // In IDLE the first enable is decoded straight from the request so it lands
  // in E the cycle after accept; afterwards cur_q holds the next group.
  always_comb begin
    dec_addr  = cur_q;
    dec_bcast = 1'b0;
    if (state_q == IDLE) begin
      dec_addr  = req.req_addr;
      dec_bcast = req.req_bcast;
    end
  end

  dgw_onehot_dec u_dec (
    .addr        (dec_addr),
    .bcast       (dec_bcast),
    .grp_disable (grp_disable),
    .grp_en      (dec_en)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    e_d     = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          e_d     = dec_en;
          cur_d   = req.req_addr + ADDR_W'(1);
          rem_d   = req.req_bcast ? '0 : req.req_len;
          done_d  = req.req_bcast || (req.req_len == '0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // rem_q counts groups still to emit after the one currently on E.
        if (rem_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          e_d    = dec_en;
          cur_d  = cur_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          done_d = (rem_q == LEN_W'(1));
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      e_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_dgw_enable_seq.sv
// Directed bench for dgw_enable_seq: one instance with a one-cycle gap, one
// with no gap; expected E/done/busy per cycle are queued and popped.
module tb_dgw_enable_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dis;
  logic [15:0] E_a, E_b;
  logic        busy_a, busy_b, done_a, done_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] e;
    logic        done;
    logic        busy;
    logic        bcast;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  dgw_enable_seq_if ifa ();
  dgw_enable_seq_if ifb ();

  dgw_enable_seq #(.GAP_CYCLES(1)) u_dut_a (
    .clk (clk), .rst (rst), .req (ifa), .grp_disable (dis),
    .E (E_a), .busy (busy_a), .done (done_a)
  );

  dgw_enable_seq #(.GAP_CYCLES(0)) u_dut_b (
    .clk (clk), .rst (rst), .req (ifb), .grp_disable (dis),
    .E (E_b), .busy (busy_b), .done (done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int addr, input int len, input bit bcast,
                            input logic [15:0] mask, input int gap);
    exp_t x;
    if (bcast) begin
      x = '{e: 16'hFFFF & ~mask, done: 1'b1, busy: 1'b1, bcast: 1'b1};
      q.push_back(x);
    end else begin
      for (int i = 0; i <= len; i++) begin
        x = '{e: (16'h0001 << ((addr + i) % 16)) & ~mask, done: (i == len),
              busy: 1'b1, bcast: 1'b0};
        q.push_back(x);
      end
    end
    for (int g = 0; g < gap; g++) begin
      x = '{e: 16'h0000, done: 1'b0, busy: 1'b1, bcast: 1'b0};
      q.push_back(x);
    end
  endtask

  task automatic cmp_one(input bit sel);
    exp_t x;
    logic [15:0] oe;
    logic        od, ob;
    @(negedge clk);
    x  = q.pop_front();
    oe = sel ? E_b : E_a;
    od = sel ? done_b : done_a;
    ob = sel ? busy_b : busy_a;
    chk("E", 32'(oe), 32'(x.e));
    chk("done", 32'(od), 32'(x.done));
    chk("busy", 32'(ob), 32'(x.busy));
    if (!x.bcast) chk("onehot", 32'($countones(oe) <= 1), 32'd1);
  endtask

  task automatic drain(input bit sel);
    while (q.size() > 0) cmp_one(sel);
  endtask

  task automatic send(input bit sel, input logic [3:0] addr, input logic [3:0] len,
                      input logic bcast);
    bit rdy;
    rdy = 1'b0;
    if (sel) begin
      ifb.req_addr = addr; ifb.req_len = len; ifb.req_bcast = bcast; ifb.req_valid = 1'b1;
    end else begin
      ifa.req_addr = addr; ifa.req_len = len; ifa.req_bcast = bcast; ifa.req_valid = 1'b1;
    end
    for (int n = 0; n < 64 && !rdy; n++) begin
      @(negedge clk);
      rdy = sel ? ifb.req_ready : ifa.req_ready;
    end
    if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (sel) ifb.req_valid = 1'b0;
    else     ifa.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dis = 16'h0000;
    ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_len = '0; ifa.req_bcast = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_len = '0; ifb.req_bcast = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_E", 32'(E_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_ready_a", 32'(ifa.req_ready), 32'h0);
    chk("rst_ready_b", 32'(ifb.req_ready), 32'h0);
    rst = 1'b0;

    // Single group, addr 3, then one gap cycle
    push_burst(3, 0, 1'b0, dis, 1);
    send(1'b0, 4'd3, 4'd0, 1'b0);
    drain(1'b0);
    @(negedge clk);
    chk("t1_ready", 32'(ifa.req_ready), 32'h1);
    chk("t1_busy", 32'(busy_a), 32'h0);

    // Wrap-around 14,15,0,1
    push_burst(14, 3, 1'b0, dis, 1);
    send(1'b0, 4'd14, 4'd3, 1'b0);
    drain(1'b0);

    // Broadcast with disabled groups
    dis = 16'h00F0;
    push_burst(0, 0, 1'b1, dis, 1);
    send(1'b0, 4'd5, 4'd9, 1'b1);
    drain(1'b0);
    @(negedge clk);
    chk("t3_busy_after_gap", 32'(busy_a), 32'h0);

    // Full sweep with group 2 disabled
    dis = 16'h0004;
    push_burst(0, 15, 1'b0, dis, 1);
    send(1'b0, 4'd0, 4'd15, 1'b0);
    drain(1'b0);
    dis = 16'h0000;

    // Reset in the second cycle of a len=7 burst
    send(1'b0, 4'd5, 4'd7, 1'b0);
    @(negedge clk);
    chk("t5_first_E", 32'(E_a), 32'h0020);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_E_async", 32'(E_a), 32'h0);
    chk("t5_done", 32'(done_a), 32'h0);
    chk("t5_ready_in_rst", 32'(ifa.req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_E_held", 32'(E_a), 32'h0);
    chk("t5_ready_held", 32'(ifa.req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("t5_ready_release", 32'(ifa.req_ready), 32'h1);
    @(negedge clk);
    chk("t5_E_after", 32'(E_a), 32'h0);
    chk("t5_busy_after", 32'(busy_a), 32'h0);
    chk("t5_done_after", 32'(done_a), 32'h0);

    // Back-to-back on the no-gap instance with req_valid held
    push_burst(9, 1, 1'b0, dis, 0);
    q.push_back('{e: 16'h0000, done: 1'b0, busy: 1'b0, bcast: 1'b0});
    push_burst(9, 1, 1'b0, dis, 0);
    @(negedge clk);
    ifb.req_addr = 4'd9; ifb.req_len = 4'd1; ifb.req_bcast = 1'b0; ifb.req_valid = 1'b1;
    chk("t6_ready", 32'(ifb.req_ready), 32'h1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      cmp_one(1'b1);
      if (i == 3) ifb.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("t6_busy_end", 32'(busy_b), 32'h0);
    chk("t6_E_end", 32'(E_b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
